// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packet tracker.
// Holds the framing states, byte-0 bit positions and the default canvas limits.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } frame_state_t;

    // Bit positions inside the PS/2 status byte (byte 0 of a packet)
    localparam int BTN_L    = 0;
    localparam int BTN_R    = 1;
    localparam int SYNC_BIT = 3;
    localparam int XSIGN    = 4;
    localparam int YSIGN    = 5;
    localparam int XOVF     = 6;
    localparam int YOVF     = 7;

    localparam int DEF_XMAX         = 159;
    localparam int DEF_YMAX         = 119;
    localparam int DEF_XINIT        = 80;
    localparam int DEF_YINIT        = 60;
    localparam int DEF_SYNC_TIMEOUT = 50000;

endpackage

// File: rtl/mouse_axis_update.sv
// Combinational next-position calculation for one mouse axis.
// Applies a signed 9-bit PS/2 delta and clamps the result to 0..maxv.
module mouse_axis_update (
    input  logic [8:0] pos,
    input  logic       sign,
    input  logic [7:0] delta,
    input  logic       ovf,
    input  logic       negate,
    input  logic [8:0] maxv,
    output logic [8:0] next_pos
);

    logic signed [10:0] delta_s;
    logic signed [10:0] pos_s;
    logic signed [10:0] max_s;
    logic signed [10:0] sum_s;

    // 11 bits cover 0..511 +/- 256 without wrapping, so the clamp sees the true sum
    always_comb begin
        delta_s = ovf ? 11'sd0 : $signed({{2{sign}}, sign, delta});
        pos_s   = $signed({2'b00, pos});
        max_s   = $signed({2'b00, maxv});
        sum_s   = negate ? (pos_s - delta_s) : (pos_s + delta_s);
        if (sum_s < 11'sd0) begin
            next_pos = 9'd0;
        end else if (sum_s > max_s) begin
            next_pos = maxv;
        end else begin
            next_pos = sum_s[8:0];
        end
    end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// Frames 3-byte PS/2 mouse packets and tracks an absolute, clamped cursor position
// plus button state, pulsing packet_valid for one cycle per committed packet.
module ps2_mouse_tracker
    import ps2_mouse_pkg::*;
#(
    parameter int XMAX         = DEF_XMAX,
    parameter int YMAX         = DEF_YMAX,
    parameter int XINIT        = DEF_XINIT,
    parameter int YINIT        = DEF_YINIT,
    parameter int SYNC_TIMEOUT = DEF_SYNC_TIMEOUT
) (
    input  logic       CLOCK,
    input  logic       resetn,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_byte_en,
    output logic [8:0] mousex,
    output logic [8:0] mousey,
    output logic       leftclick,
    output logic       rightclick,
    output logic       packet_valid
);

    localparam int CW = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [8:0] XMAX_W  = 9'(XMAX);
    localparam logic [8:0] YMAX_W  = 9'(YMAX);
    localparam logic [8:0] XINIT_W = 9'(XINIT);
    localparam logic [8:0] YINIT_W = 9'(YINIT);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(SYNC_TIMEOUT - 1);

    frame_state_t  state_reg;
    logic [CW-1:0] idle_cnt_reg;
    logic [7:0]    byte0_reg;
    logic [7:0]    byte1_reg;
    logic [8:0]    mousex_reg;
    logic [8:0]    mousey_reg;
    logic          leftclick_reg;
    logic          rightclick_reg;
    logic          packet_valid_reg;

    logic [8:0]    x_next;
    logic [8:0]    y_next;
    logic          idle_expired;

    // Byte 2 is used straight off the bus so the commit happens on its own strobe edge
    mouse_axis_update u_axis_x (
        .pos      (mousex_reg),
        .sign     (byte0_reg[XSIGN]),
        .delta    (byte1_reg),
        .ovf      (byte0_reg[XOVF]),
        .negate   (1'b0),
        .maxv     (XMAX_W),
        .next_pos (x_next)
    );

    // PS/2 reports +Y as up while row 0 is the top of the canvas
    mouse_axis_update u_axis_y (
        .pos      (mousey_reg),
        .sign     (byte0_reg[YSIGN]),
        .delta    (ps2_byte),
        .ovf      (byte0_reg[YOVF]),
        .negate   (1'b1),
        .maxv     (YMAX_W),
        .next_pos (y_next)
    );

    assign idle_expired = (idle_cnt_reg == TIMEOUT_LAST);

    always_ff @(posedge CLOCK or negedge resetn) begin
        if (!resetn) begin
            state_reg        <= WAIT_B0;
            idle_cnt_reg     <= '0;
            byte0_reg        <= '0;
            byte1_reg        <= '0;
            mousex_reg       <= XINIT_W;
            mousey_reg       <= YINIT_W;
            leftclick_reg    <= 1'b0;
            rightclick_reg   <= 1'b0;
            packet_valid_reg <= 1'b0;
        end else begin
            packet_valid_reg <= 1'b0;
            case (state_reg)
                WAIT_B0: begin
                    idle_cnt_reg <= '0;
                    // Bytes without the always-one sync bit cannot start a packet
                    if (ps2_byte_en && ps2_byte[SYNC_BIT]) begin
                        byte0_reg <= ps2_byte;
                        state_reg <= WAIT_B1;
                    end
                end
                WAIT_B1: begin
                    if (ps2_byte_en) begin
                        byte1_reg    <= ps2_byte;
                        idle_cnt_reg <= '0;
                        state_reg    <= WAIT_B2;
                    end else if (idle_expired) begin
                        idle_cnt_reg <= '0;
                        state_reg    <= WAIT_B0;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + CW'(1);
                    end
                end
                WAIT_B2: begin
                    if (ps2_byte_en) begin
                        mousex_reg       <= x_next;
                        mousey_reg       <= y_next;
                        leftclick_reg    <= byte0_reg[BTN_L];
                        rightclick_reg   <= byte0_reg[BTN_R];
                        packet_valid_reg <= 1'b1;
                        idle_cnt_reg     <= '0;
                        state_reg        <= WAIT_B0;
                    end else if (idle_expired) begin
                        idle_cnt_reg <= '0;
                        state_reg    <= WAIT_B0;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + CW'(1);
                    end
                end
                default: begin
                    idle_cnt_reg <= '0;
                    state_reg    <= WAIT_B0;
                end
            endcase
        end
    end

    assign mousex       = mousex_reg;
    assign mousey       = mousey_reg;
    assign leftclick    = leftclick_reg;
    assign rightclick   = rightclick_reg;
    assign packet_valid = packet_valid_reg;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed bench for ps2_mouse_tracker: hand-computed packets covering framing,
// clamping, resync, idle timeout, overflow handling and mid-packet reset.
module tb_ps2_mouse_tracker;

    logic       CLOCK;
    logic       resetn;
    logic [7:0] ps2_byte;
    logic       ps2_byte_en;
    logic [8:0] mousex;
    logic [8:0] mousey;
    logic       leftclick;
    logic       rightclick;
    logic       packet_valid;

    int n_checks;
    int n_fail;
    int pv_count;
    int pv_mark;

    ps2_mouse_tracker dut (
        .CLOCK        (CLOCK),
        .resetn       (resetn),
        .ps2_byte     (ps2_byte),
        .ps2_byte_en  (ps2_byte_en),
        .mousex       (mousex),
        .mousey       (mousey),
        .leftclick    (leftclick),
        .rightclick   (rightclick),
        .packet_valid (packet_valid)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Total pulse count sampled away from the active edge
    initial pv_count = 0;
    always @(negedge CLOCK) begin
        if (packet_valid) pv_count <= pv_count + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end else begin
            $display("ok   %s: %0d", tag, observed);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLOCK);
        ps2_byte    = b;
        ps2_byte_en = 1'b1;
        @(negedge CLOCK);
        ps2_byte_en = 1'b0;
        ps2_byte    = 8'h00;
    endtask

    // After the third strobe the task sits one cycle past the commit edge
    task automatic send_packet(input string tag, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        send_byte(b1);
        check_val({tag, " pv low before commit"}, 32'(packet_valid), 32'd0);
        send_byte(b2);
        check_val({tag, " pv pulse"}, 32'(packet_valid), 32'd1);
        @(negedge CLOCK);
        check_val({tag, " pv drops"}, 32'(packet_valid), 32'd0);
        $display("packet %s: %02h %02h %02h -> x=%0d y=%0d L=%0d R=%0d", tag, b0, b1, b2, mousex, mousey, leftclick, rightclick);
    endtask

    task automatic do_reset;
        @(negedge CLOCK);
        resetn = 1'b0;
        repeat (2) @(negedge CLOCK);
        resetn = 1'b1;
        @(negedge CLOCK);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        resetn      = 1'b0;
        ps2_byte    = 8'h00;
        ps2_byte_en = 1'b0;
        repeat (3) @(negedge CLOCK);
        resetn = 1'b1;
        repeat (2) @(negedge CLOCK);

        check_val("reset mousex", 32'(mousex), 32'd80);
        check_val("reset mousey", 32'(mousey), 32'd60);
        check_val("reset left", 32'(leftclick), 32'd0);
        check_val("reset right", 32'(rightclick), 32'd0);
        check_val("reset pv", 32'(packet_valid), 32'd0);

        send_packet("basic", 8'h09, 8'h05, 8'h03);
        check_val("basic mousex", 32'(mousex), 32'd85);
        check_val("basic mousey", 32'(mousey), 32'd57);
        check_val("basic left", 32'(leftclick), 32'd1);

        send_packet("clamp_lo", 8'h18, 8'h9C, 8'h00);
        check_val("clamp_lo mousex", 32'(mousex), 32'd0);
        check_val("clamp_lo mousey", 32'(mousey), 32'd57);
        check_val("clamp_lo left", 32'(leftclick), 32'd0);

        send_packet("clamp_hi1", 8'h08, 8'h7F, 8'h00);
        check_val("clamp_hi1 mousex", 32'(mousex), 32'd127);
        send_packet("clamp_hi2", 8'h08, 8'h7F, 8'h00);
        check_val("clamp_hi2 mousex", 32'(mousex), 32'd159);

        send_packet("clamp_y", 8'h08, 8'h00, 8'h7F);
        check_val("clamp_y mousey", 32'(mousey), 32'd0);
        check_val("clamp_y mousex", 32'(mousex), 32'd159);

        pv_mark = pv_count;
        send_byte(8'h05);
        check_val("resync stray no pv", 32'(packet_valid), 32'd0);
        send_packet("resync", 8'h0A, 8'h00, 8'h00);
        check_val("resync right", 32'(rightclick), 32'd1);
        check_val("resync left", 32'(leftclick), 32'd0);
        check_val("resync mousex", 32'(mousex), 32'd159);
        check_val("resync mousey", 32'(mousey), 32'd0);
        check_val("resync pulse count", 32'(pv_count - pv_mark), 32'd1);

        do_reset();
        check_val("reset2 mousex", 32'(mousex), 32'd80);
        check_val("reset2 right", 32'(rightclick), 32'd0);
        pv_mark = pv_count;
        send_byte(8'h09);
        send_byte(8'h05);
        repeat (50005) @(negedge CLOCK);
        check_val("timeout no pv", 32'(pv_count - pv_mark), 32'd0);
        send_packet("timeout", 8'h08, 8'h01, 8'h01);
        check_val("timeout mousex", 32'(mousex), 32'd81);
        check_val("timeout mousey", 32'(mousey), 32'd59);
        check_val("timeout left", 32'(leftclick), 32'd0);
        check_val("timeout pulse count", 32'(pv_count - pv_mark), 32'd1);

        do_reset();
        send_packet("xovf", 8'h48, 8'h10, 8'h04);
        check_val("xovf mousex", 32'(mousex), 32'd80);
        check_val("xovf mousey", 32'(mousey), 32'd56);

        pv_mark = pv_count;
        send_byte(8'h09);
        send_byte(8'h05);
        @(negedge CLOCK);
        resetn = 1'b0;
        #1;
        check_val("async reset mousey", 32'(mousey), 32'd60);
        repeat (2) @(negedge CLOCK);
        resetn = 1'b1;
        send_byte(8'h14);
        repeat (3) @(negedge CLOCK);
        check_val("midreset mousex", 32'(mousex), 32'd80);
        check_val("midreset mousey", 32'(mousey), 32'd60);
        check_val("midreset left", 32'(leftclick), 32'd0);
        check_val("midreset pulse count", 32'(pv_count - pv_mark), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
